instr_queue: RTL and testbench

INSTR_QUEUE -- requirements
Module: instr_queue

---
 rtl/instr_queue.sv | 110 +++++++++++
 tb/tb_instr_queue.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_queue.sv
// Halfword instruction queue between ICache fetch and Thumb/Thumb-2 decode.
// Accepts one 16-bit halfword per cycle and presents whole 16- or 32-bit instructions at the head.
module instr_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       not_reset,
  input  logic                       in_valid,
  input  logic [31:0]                in_index,
  input  logic [15:0]                in_data,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic                       out_wide,
  output logic [31:0]                out_data,
  output logic [31:0]                out_index,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [15:0]   r_data  [DEPTH];
  logic [31:0]   r_index [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [PW-1:0] w_head_plus1;
  logic [15:0]   w_hw0;
  logic [15:0]   w_hw1;
  logic          w_wide;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_pop_cnt;

  assign w_head_plus1 = r_head + PW'(1);
  assign w_hw0        = r_data[r_head];
  assign w_hw1        = r_data[w_head_plus1];

  // Prefixes 11101/11110/11111 open a 32-bit Thumb-2 encoding.
  assign w_wide = (w_hw0[15:13] == 3'b111) && (w_hw0[12:11] != 2'b00);

  // NOTE: always_comb assigns every output a default first, so no path leaves a
  // signal unassigned and no latch can be inferred.
  always_comb begin
    w_valid   = 1'b0;
    w_pop_cnt = 2'd0;
    if (w_wide) begin
      w_valid = (r_count >= CW'(2));
    end else begin
      w_valid = (r_count >= CW'(1));
    end
    w_pop = w_valid && out_ready && !flush;
    if (w_pop) begin
      w_pop_cnt = w_wide ? 2'd2 : 2'd1;
    end
  end

  // Readiness depends only on the registered occupancy, never on the consumer side.
  assign in_ready = (r_count < FULL_COUNT);
  assign w_push   = in_valid && in_ready && !flush;

  always_comb begin
    out_valid = w_valid;
    out_wide  = w_wide;
    out_index = r_index[r_head];
    out_data  = {16'h0000, w_hw0};
    if (w_wide) begin
      out_data = {w_hw0, w_hw1};
    end
  end

  assign count = r_count;

  // NOTE: the entry storage is reset as well, so the head outputs read 0 rather
  // than X after reset and stale data never leaks as unknowns.
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i]  <= '0;
        r_index[i] <= '0;
      end
    end else if (w_push) begin
      r_data[r_tail]  <= in_data;
      r_index[r_tail] <= in_index;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, matching the hardware it describes.
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop_cnt);
      r_tail  <= r_tail + PW'(w_push);
      r_count <= r_count + CW'(w_push) - CW'(w_pop_cnt);
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed vector table, hand-written
// corner sequences, and a random run against a queue-based reference model.
module tb_instr_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        not_reset;
  logic        in_valid;
  logic [31:0] in_index;
  logic [15:0] in_data;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic        out_wide;
  logic [31:0] out_data;
  logic [31:0] out_index;
  logic [2:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .not_reset (not_reset),
    .in_valid  (in_valid),
    .in_index  (in_index),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_wide  (out_wide),
    .out_data  (out_data),
    .out_index (out_index),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] idx;
    logic [15:0] dat;
    logic        fl;
    logic        ordy;
    int          e_count;
    logic        e_valid;
    logic        e_wide;
    logic [31:0] e_data;
    logic [31:0] e_index;
    logic        e_ready;
  } vec_t;

  typedef struct packed {
    logic [31:0] idx;
    logic [15:0] dat;
  } hw_t;

  hw_t mq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [31:0] idx, input logic [15:0] dat,
                              input logic fl, input logic ordy, input int e_count,
                              input logic e_valid, input logic e_wide, input logic [31:0] e_data,
                              input logic [31:0] e_index, input logic e_ready);
    vec_t v;
    v.iv = iv; v.idx = idx; v.dat = dat; v.fl = fl; v.ordy = ordy;
    v.e_count = e_count; v.e_valid = e_valid; v.e_wide = e_wide;
    v.e_data = e_data; v.e_index = e_index; v.e_ready = e_ready;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [31:0] idx, input logic [15:0] dat,
                       input logic fl, input logic ordy);
    in_valid  = iv;
    in_index  = idx;
    in_data   = dat;
    flush     = fl;
    out_ready = ordy;
  endtask

  // Drive idle inputs, hold reset over two edges, release between edges.
  task automatic apply_reset(input bit do_checks);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    not_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (do_checks) begin
      check("rst_count",     32'(count),     32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  out_data,       32'd0);
    end
    @(negedge clk);
    not_reset = 1'b1;
    @(posedge clk);
    #1;
    if (do_checks) begin
      check("post_rst_count", 32'(count),     32'd0);
      check("post_rst_valid", 32'(out_valid), 32'd0);
      check("post_rst_wide",  32'(out_wide),  32'd0);
      check("post_rst_index", out_index,      32'd0);
      check("post_rst_data",  out_data,       32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_wide_hw(input logic [15:0] hw);
    return (hw[15:11] == 5'b11101) || (hw[15:11] == 5'b11110) || (hw[15:11] == 5'b11111);
  endfunction

  function automatic bit m_wide();
    return (mq.size() > 0) && is_wide_hw(mq[0].dat);
  endfunction

  function automatic bit m_valid();
    if (mq.size() == 0) return 1'b0;
    return m_wide() ? (mq.size() >= 2) : 1'b1;
  endfunction

  vec_t vecs[12];

  initial begin
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    not_reset = 1'b0;

    // Directed table; entries are {inputs} -> {state after the edge}.
    vecs[0]  = mk(1, 32'd10, 16'h2001, 0, 0, 1, 1, 0, 32'h00002001, 32'd10, 1);
    vecs[1]  = mk(1, 32'd11, 16'h4608, 0, 0, 2, 1, 0, 32'h00002001, 32'd10, 1);
    vecs[2]  = mk(1, 32'd12, 16'h1234, 0, 0, 3, 1, 0, 32'h00002001, 32'd10, 1);
    vecs[3]  = mk(1, 32'd13, 16'h5678, 0, 0, 4, 1, 0, 32'h00002001, 32'd10, 0);
    vecs[4]  = mk(1, 32'd14, 16'h9999, 0, 0, 4, 1, 0, 32'h00002001, 32'd10, 0);
    vecs[5]  = mk(0, 32'd0,  16'h0000, 0, 1, 3, 1, 0, 32'h00004608, 32'd11, 1);
    vecs[6]  = mk(1, 32'd15, 16'h0AAA, 0, 1, 3, 1, 0, 32'h00001234, 32'd12, 1);
    vecs[7]  = mk(1, 32'd16, 16'hBBBB, 1, 1, 0, 0, 0, 32'h0,        32'd0,  1);
    vecs[8]  = mk(0, 32'd0,  16'h0000, 0, 1, 0, 0, 0, 32'h0,        32'd0,  1);
    vecs[9]  = mk(1, 32'd20, 16'hF000, 0, 1, 1, 0, 0, 32'h0,        32'd0,  1);
    vecs[10] = mk(1, 32'd21, 16'hF800, 0, 0, 2, 1, 1, 32'hF000F800, 32'd20, 1);
    vecs[11] = mk(0, 32'd0,  16'h0000, 0, 1, 0, 0, 0, 32'h0,        32'd0,  1);

    apply_reset(1'b1);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].iv, vecs[i].idx, vecs[i].dat, vecs[i].fl, vecs[i].ordy);
      step();
      check($sformatf("vec%0d_count", i),    32'(count),     32'(vecs[i].e_count));
      check($sformatf("vec%0d_valid", i),    32'(out_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready),  32'(vecs[i].e_ready));
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_wide", i),  32'(out_wide), 32'(vecs[i].e_wide));
        check($sformatf("vec%0d_data", i),  out_data,      vecs[i].e_data);
        check($sformatf("vec%0d_index", i), out_index,     vecs[i].e_index);
      end
    end

    // Wide instruction split across the pointer wrap (slots 3 and 0).
    apply_reset(1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'(k), 16'h0100 + 16'(k), 0, 0);
      step();
      drive(0, '0, '0, 0, 1);
      step();
    end
    check("wrap_empty", 32'(count), 32'd0);
    drive(1, 32'd30, 16'hF7FF, 0, 0);
    step();
    check("wrap_half_valid", 32'(out_valid), 32'd0);
    drive(1, 32'd31, 16'hFFFE, 0, 0);
    step();
    check("wrap_valid", 32'(out_valid), 32'd1);
    check("wrap_wide",  32'(out_wide),  32'd1);
    check("wrap_data",  out_data,       32'hF7FFFFFE);
    check("wrap_index", out_index,      32'd30);
    drive(0, '0, '0, 0, 1);
    step();
    check("wrap_pop_count", 32'(count), 32'd0);

    // Asynchronous reset between edges with two entries queued.
    drive(1, 32'd40, 16'h1111, 0, 0);
    step();
    drive(1, 32'd41, 16'h2222, 0, 0);
    step();
    drive(0, '0, '0, 0, 0);
    check("async_pre_count", 32'(count), 32'd2);
    #2;
    not_reset = 1'b0;
    #1;
    check("async_count", 32'(count),     32'd0);
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_data",  out_data,       32'd0);
    @(negedge clk);
    not_reset = 1'b1;
    step();

    // Random traffic against the queue model.
    mq.delete();
    for (int c = 0; c < 2000; c++) begin
      logic        iv, fl, ordy;
      logic [31:0] idx;
      logic [15:0] dat;
      bit          rdy_pre, valid_pre, wide_pre;
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      fl   = ($urandom_range(0, 15) == 0);
      idx  = $urandom;
      dat  = 16'($urandom);
      if ($urandom_range(0, 2) == 0) dat[15:11] = 5'd29 + 5'($urandom_range(0, 2));
      drive(iv, idx, dat, fl, ordy);

      rdy_pre   = (mq.size() < DEPTH);
      valid_pre = m_valid();
      wide_pre  = m_wide();
      if (fl) begin
        mq.delete();
      end else begin
        if (valid_pre && ordy) begin
          void'(mq.pop_front());
          if (wide_pre) void'(mq.pop_front());
        end
        if (iv && rdy_pre) mq.push_back('{idx: idx, dat: dat});
      end

      step();
      check("rnd_count",    32'(count),     32'(mq.size()));
      check("rnd_in_ready", 32'(in_ready),  32'(mq.size() < DEPTH));
      check("rnd_valid",    32'(out_valid), 32'(m_valid()));
      if (m_valid()) begin
        check("rnd_wide",  32'(out_wide), 32'(m_wide()));
        check("rnd_index", out_index,     mq[0].idx);
        check("rnd_data",  out_data,      m_wide() ? {mq[0].dat, mq[1].dat} : {16'h0, mq[0].dat});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
